stopwatch: RTL and testbench
============================

// Module: stopwatch
// PURPOSE
//  Count-up stopwatch core with start/stop, lap-hold and clear controls.
//  Counts M:SS.t from 0:00.0 to 9:59.9 from the 12 MHz board clock.
//  Takes single-cycle pulses from the existing debouncers.
//  Feeds four BCD digits to display_7_seg, with digit 0 = tenths.
// PARAMETERS
//  CLK_HZ   12000000  input clock frequency
//  TICK_HZ  10        count rate, one tenth-second per tick; DIV = CLK_HZ/TICK_HZ
// PORTS
//  CLK           in   1  system clock
//  RST           in   1  synchronous, active-high reset
//  s_start_stop  in   1  one-cycle pulse: start / pause / resume
//  s_lap         in   1  one-cycle pulse: freeze display / release display
//  s_clear       in   1  one-cycle pulse: return to zero
//  tenths        out  4  displayed tenths, BCD 0-9
//  secs          out  4  displayed seconds units, BCD 0-9
//  ten_secs      out  4  displayed seconds tens, BCD 0-5
//  mins          out  4  displayed minutes, BCD 0-9
//  running       out  1  live count is advancing (RUNNING or LAPPED)
//  lap_held      out  1  display is frozen on a lap capture
//  overflow      out  1  count saturated at 9:59.9
// BEHAVIOUR
//  - RST: state=IDLE; live count, lap registers and prescaler = 0.
//    All outputs are 0.
//  - States: IDLE, RUNNING, PAUSED, LAPPED, MAXED.
//  - Input priority in one cycle: RST > s_clear > s_start_stop > s_lap.
//    Only the highest-priority pulse takes effect.
//  - IDLE: s_start_stop -> RUNNING with prescaler=0. s_lap ignored.
//  - RUNNING:
//      s_start_stop -> PAUSED.
//      s_lap -> copy live count into lap registers; go to LAPPED.
//  - LAPPED: live count keeps advancing.
//      s_lap -> RUNNING (display follows live count again).
//      s_start_stop -> PAUSED (display shows the live count).
//  - PAUSED: prescaler and count hold; the fraction is kept on resume.
//      s_start_stop -> RUNNING. s_lap ignored.
//  - MAXED: count frozen at 9:59.9, overflow=1.
//      s_start_stop and s_lap ignored.
//  - s_clear in any state -> IDLE.
//    Zeroes count, lap registers and prescaler; clears overflow and lap_held.
//  - Prescaler: counts 0..DIV-1 only in RUNNING/LAPPED.
//    Tick = (prescaler == DIV-1); prescaler then wraps to 0.
//    The count changes on the same edge as the tick.
//  - BCD carry chain:
//      tenths 9->0 carries into secs;
//      secs 9->0 carries into ten_secs;
//      ten_secs 5->0 carries into mins.
//  - Saturation: a tick at 9:59.9 does not wrap.
//    Count holds at 9:59.9; state -> MAXED; overflow=1 from the next cycle.
//    If in LAPPED, the lap display is released.
//  - Display outputs are a registered select:
//    lap registers when lap_held=1, otherwise the live count.
//    Latency is one cycle after the state/count update.
//  - A pulse arriving on the tick cycle is applied together with that tick.
//    Example: s_lap on a tick captures the post-tick value.
//  - Digits never leave legal BCD ranges. Arithmetic is 4-bit per digit.
// STRUCTURE
//  - Shared package/include stopwatch_defs:
//    state localparams (IDLE..MAXED) and the 3-bit state width;
//    MAX_TENTHS=9, MAX_SECS=9, MAX_TEN_SECS=5, MAX_MINS=9.
//  - One sub-module, bcd_digit:
//    4-bit count with parameterised max, inc_in, clr, carry_out = inc_in & (q==max).
//    Instantiate four of them in a chain.
//  - Top level: prescaler, FSM, lap registers, output mux.
// TESTING  (CLK_HZ=100, TICK_HZ=10 -> DIV=10)
//  1. RST, then s_start_stop, then 125 cycles.
//     -> digits 0:01.2, running=1, overflow=0.
//  2. Run to 0:59.9, then one more tick.
//     -> 1:00.0 with a correct carry through ten_secs 5->0.
//  3. Run to 0:03.0; s_lap; run 20 cycles more.
//     -> display holds 0:03.0, lap_held=1.
//     Second s_lap -> display shows 0:05.0.
//  4. Run 47 cycles; s_start_stop; wait 100 cycles; s_start_stop; 3 cycles.
//     -> 0:00.4 held during the pause; tick lands at cycle 50 -> 0:00.5.
//  5. Preload 9:59.8 via forced run; 2 ticks.
//     -> 9:59.9, state MAXED, overflow=1; s_start_stop ignored.
//     s_clear -> 0:00.0, overflow=0.
//  6. s_clear and s_start_stop in the same cycle while RUNNING -> IDLE, zeros.
//     RST mid-LAPPED -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/stopwatch_defs.sv
// Shared definitions for the stopwatch: FSM state encoding and per-digit BCD limits.
package stopwatch_defs;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        RUNNING = 3'd1,
        PAUSED  = 3'd2,
        LAPPED  = 3'd3,
        MAXED   = 3'd4
    } state_t;

    localparam logic [3:0] MAX_TENTHS   = 4'd9;
    localparam logic [3:0] MAX_SECS     = 4'd9;
    localparam logic [3:0] MAX_TEN_SECS = 4'd5;
    localparam logic [3:0] MAX_MINS     = 4'd9;

    // Digit index 0 is tenths, 3 is minutes.
    function automatic logic [3:0] digit_max(input int idx);
        case (idx)
            0:       digit_max = MAX_TENTHS;
            1:       digit_max = MAX_SECS;
            2:       digit_max = MAX_TEN_SECS;
            default: digit_max = MAX_MINS;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit of the count chain: increments on inc_in, wraps at MAX and carries out.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       inc_in,
    input  logic       clr,
    input  logic       hold,
    output logic [3:0] q,
    output logic [3:0] q_next,
    output logic       carry_out
);

    assign carry_out = inc_in & (q == MAX);

    // hold freezes the digit when the whole chain would wrap past the top value.
    always_comb begin
        q_next = q;
        if (clr) begin
            q_next = '0;
        end else if (inc_in && !hold) begin
            q_next = (q >= MAX) ? 4'd0 : q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/stopwatch.sv
// Count-up M:SS.t stopwatch: prescaler, control FSM, lap capture and registered display select.
module stopwatch
    import stopwatch_defs::*;
#(
    parameter int CLK_HZ  = 12000000,
    parameter int TICK_HZ = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       s_start_stop,
    input  logic       s_lap,
    input  logic       s_clear,
    output logic [3:0] tenths,
    output logic [3:0] secs,
    output logic [3:0] ten_secs,
    output logic [3:0] mins,
    output logic       running,
    output logic       lap_held,
    output logic       overflow
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    state_t           state_reg;
    logic [PRE_W-1:0] pre_reg;
    logic [3:0]       lap_reg   [4];
    logic [3:0]       disp_reg  [4];
    logic [3:0]       digit_q   [4];
    logic [3:0]       digit_next[4];
    logic             counting;
    logic             tick;
    logic             sat;

    assign counting = (state_reg == RUNNING) || (state_reg == LAPPED);
    assign tick     = counting && (pre_reg == PRE_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_digit
            logic inc;
            logic carry;
            if (gi == 0) begin : g_first
                assign inc = tick;
            end else begin : g_next
                assign inc = gen_digit[gi-1].carry;
            end
            bcd_digit #(
                .MAX(digit_max(gi))
            ) u_digit (
                .clk      (CLK),
                .srst     (RST),
                .inc_in   (inc),
                .clr      (s_clear),
                .hold     (sat),
                .q        (digit_q[gi]),
                .q_next   (digit_next[gi]),
                .carry_out(carry)
            );
        end
    endgenerate

    // A carry out of the minutes digit means the tick arrived at 9:59.9.
    assign sat = gen_digit[3].carry;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            pre_reg   <= '0;
            lap_reg   <= '{default: '0};
            disp_reg  <= '{default: '0};
            running   <= 1'b0;
            lap_held  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                disp_reg[i] <= lap_held ? lap_reg[i] : digit_q[i];
            end
            if (s_clear) begin
                state_reg <= IDLE;
                pre_reg   <= '0;
                lap_reg   <= '{default: '0};
                running   <= 1'b0;
                lap_held  <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (counting) begin
                    pre_reg <= tick ? '0 : pre_reg + PRE_W'(1);
                end
                if (sat) begin
                    state_reg <= MAXED;
                    running   <= 1'b0;
                    lap_held  <= 1'b0;
                    overflow  <= 1'b1;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            if (s_start_stop) begin
                                state_reg <= RUNNING;
                                pre_reg   <= '0;
                                running   <= 1'b1;
                            end
                        end
                        RUNNING: begin
                            if (s_start_stop) begin
                                state_reg <= PAUSED;
                                running   <= 1'b0;
                            end else if (s_lap) begin
                                // Capture the post-tick value when the lap lands on a tick.
                                lap_reg   <= digit_next;
                                state_reg <= LAPPED;
                                lap_held  <= 1'b1;
                            end
                        end
                        LAPPED: begin
                            if (s_start_stop) begin
                                state_reg <= PAUSED;
                                running   <= 1'b0;
                                lap_held  <= 1'b0;
                            end else if (s_lap) begin
                                state_reg <= RUNNING;
                                lap_held  <= 1'b0;
                            end
                        end
                        PAUSED: begin
                            if (s_start_stop) begin
                                state_reg <= RUNNING;
                                running   <= 1'b1;
                            end
                        end
                        MAXED: begin
                        end
                        default: begin
                            state_reg <= IDLE;
                            running   <= 1'b0;
                            lap_held  <= 1'b0;
                            overflow  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign tenths   = disp_reg[0];
    assign secs     = disp_reg[1];
    assign ten_secs = disp_reg[2];
    assign mins     = disp_reg[3];

endmodule

// File: tb/tb_stopwatch.sv
// Scoreboard bench for the stopwatch: directed timing scenarios plus a model-checked random pulse run.
module tb_stopwatch;

    localparam int DIV = 10;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       s_start_stop = 1'b0;
    logic       s_lap = 1'b0;
    logic       s_clear = 1'b0;
    logic [3:0] tenths, secs, ten_secs, mins;
    logic       running, lap_held, overflow;

    stopwatch #(
        .CLK_HZ (100),
        .TICK_HZ(10)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .s_start_stop(s_start_stop),
        .s_lap       (s_lap),
        .s_clear     (s_clear),
        .tenths      (tenths),
        .secs        (secs),
        .ten_secs    (ten_secs),
        .mins        (mins),
        .running     (running),
        .lap_held    (lap_held),
        .overflow    (overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [15:0] digits;
        logic        run;
        logic        lh;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: count held as an integer number of tenths.
    int m_state = 0;
    int m_cnt   = 0;
    int m_pre   = 0;
    int m_lap   = 0;
    int m_disp  = 0;
    bit m_run   = 0;
    bit m_lh    = 0;
    bit m_ovf   = 0;

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'(v / 600), 4'((v / 100) % 6), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp_v);
        end
    endtask

    task automatic model_step(input bit rst, input bit ss, input bit lp, input bit clr);
        int  nd;
        bit  tick;
        bit  sat;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_pre = 0; m_lap = 0; m_disp = 0;
            m_run = 0; m_lh = 0; m_ovf = 0;
        end else begin
            nd = m_lh ? m_lap : m_cnt;
            if (clr) begin
                m_state = 0; m_cnt = 0; m_lap = 0; m_pre = 0;
            end else begin
                tick = (m_state == 1 || m_state == 3) && (m_pre == DIV - 1);
                sat  = 0;
                if (m_state == 1 || m_state == 3) m_pre = tick ? 0 : m_pre + 1;
                if (tick) begin
                    if (m_cnt == 5999) sat = 1;
                    else m_cnt++;
                end
                if (sat) begin
                    m_state = 4;
                end else begin
                    case (m_state)
                        0: if (ss) begin m_state = 1; m_pre = 0; end
                        1: if (ss) m_state = 2;
                           else if (lp) begin m_lap = m_cnt; m_state = 3; end
                        2: if (ss) m_state = 1;
                        3: if (ss) m_state = 2;
                           else if (lp) m_state = 1;
                        default: ;
                    endcase
                end
            end
            m_run  = (m_state == 1) || (m_state == 3);
            m_lh   = (m_state == 3);
            m_ovf  = (m_state == 4);
            m_disp = nd;
        end
    endtask

    // One clock: drive pulses, update the model on the edge, release at the falling edge.
    task automatic cycle(input bit rst, input bit ss, input bit lp, input bit clr);
        RST = rst; s_start_stop = ss; s_lap = lp; s_clear = clr;
        @(posedge CLK);
        model_step(rst, ss, lp, clr);
        @(negedge CLK);
        RST = 1'b0; s_start_stop = 1'b0; s_lap = 1'b0; s_clear = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0);
    endtask

    task automatic push_const(input string tag, input logic [15:0] d, input bit r, input bit l, input bit o);
        exp_t e;
        e.tag = tag; e.digits = d; e.run = r; e.lh = l; e.ovf = o;
        sb_q.push_back(e);
    endtask

    task automatic push_model(input string tag);
        push_const(tag, to_bcd(m_disp), m_run, m_lh, m_ovf);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({e.tag, ".disp"}, {mins, ten_secs, secs, tenths}, e.digits);
            check_val({e.tag, ".running"}, 16'(running), 16'(e.run));
            check_val({e.tag, ".lap_held"}, 16'(lap_held), 16'(e.lh));
            check_val({e.tag, ".overflow"}, 16'(overflow), 16'(e.ovf));
            $display("txn %s: disp=%h run=%0b lap=%0b ovf=%0b", e.tag,
                     {mins, ten_secs, secs, tenths}, running, lap_held, overflow);
        end
    endtask

    initial begin
        int r;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        push_const("reset", 16'h0000, 0, 0, 0); drain();

        // 1: start then 125 cycles
        cycle(0, 1, 0, 0);
        run(125);
        push_const("t1_run125", 16'h0012, 1, 0, 0); drain();

        // 2: carry through ten_secs 5->0
        run(5866);
        push_const("t2_0599", 16'h0599, 1, 0, 0); drain();
        run(10);
        push_const("t2_1000", 16'h1000, 1, 0, 0); drain();

        // 3: lap capture on a tick, hold, then release on a tick
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        run(299);
        cycle(0, 0, 1, 0);
        run(20);
        push_const("t3_lap_hold", 16'h0030, 1, 1, 0); drain();
        run(179);
        cycle(0, 0, 1, 0);
        run(1);
        push_const("t3_lap_release", 16'h0050, 1, 0, 0); drain();

        // 4: pause keeps the fraction
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        run(47);
        cycle(0, 1, 0, 0);
        run(100);
        push_const("t4_paused", 16'h0004, 0, 0, 0); drain();
        cycle(0, 1, 0, 0);
        run(2);
        push_const("t4_resume_pre", 16'h0004, 1, 0, 0); drain();
        run(1);
        push_const("t4_resume_tick", 16'h0005, 1, 0, 0); drain();

        // 5: saturation at 9:59.9
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        run(59991);
        push_const("t5_top", 16'h9599, 1, 0, 0); drain();
        run(10);
        push_const("t5_maxed", 16'h9599, 0, 0, 1); drain();
        cycle(0, 1, 0, 0);
        run(15);
        push_const("t5_ss_ignored", 16'h9599, 0, 0, 1); drain();
        cycle(0, 0, 0, 1);
        run(1);
        push_const("t5_clear", 16'h0000, 0, 0, 0); drain();

        // 6: clear beats start_stop; reset while lapped
        cycle(0, 1, 0, 0);
        run(25);
        push_const("t6_running", 16'h0002, 1, 0, 0); drain();
        cycle(0, 1, 0, 1);
        run(1);
        push_const("t6_clr_ss", 16'h0000, 0, 0, 0); drain();
        run(5);
        push_const("t6_idle", 16'h0000, 0, 0, 0); drain();
        cycle(0, 1, 0, 0);
        run(35);
        cycle(0, 0, 1, 0);
        run(3);
        push_const("t6_lapped", 16'h0003, 1, 1, 0); drain();
        cycle(1, 0, 0, 0);
        push_const("t6_rst", 16'h0000, 0, 0, 0); drain();

        // Random pulse mix checked against the model
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 19));
            case (r)
                0: cycle(0, 1, 0, 0);
                1: cycle(0, 0, 1, 0);
                2: cycle(0, 0, 0, 1);
                3: cycle(0, 1, 1, 0);
                4: cycle(0, 1, 0, 1);
                default: cycle(0, 0, 0, 0);
            endcase
            if (n % 20 == 19) begin
                push_model($sformatf("rnd%0d", n));
                drain();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
